// File: rtl/param_sync_fifo_pkg.sv
// Shared definitions for param_sync_fifo: width helpers, the status-flag bundle
// and its reset value.
package param_sync_fifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    localparam logic RST_FULL         = 1'b0;
    localparam logic RST_EMPTY        = 1'b1;
    localparam logic RST_ALMOST_FULL  = 1'b0;
    localparam logic RST_ALMOST_EMPTY = 1'b1;

    localparam fifo_flags_t RST_FLAGS = '{
        full:         RST_FULL,
        empty:        RST_EMPTY,
        almost_full:  RST_ALMOST_FULL,
        almost_empty: RST_ALMOST_EMPTY
    };

    // Address width for DEPTH entries; at least one bit so DEPTH=2 still works.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Occupancy width: must represent 0..DEPTH inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/param_sync_fifo_mem.sv
// WIDTH x DEPTH storage for param_sync_fifo: one synchronous write port,
// one asynchronous read port. Contents are never reset.
module param_sync_fifo_mem
    import param_sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        wr_en,
    input  logic [ptr_width(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic [ptr_width(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]            rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with occupancy count, threshold flags and
// error pulses. Define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module param_sync_fifo
    import param_sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned AFULL_TH  = DEPTH - 1,
    parameter int unsigned AEMPTY_TH = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic                        data_in_vld,
    input  logic [WIDTH-1:0]            data_in,
    input  logic                        rd_en,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic [WIDTH-1:0]            rd_data,
    output logic                        data_out_vld,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             wr_fifo;
    logic             rd_fifo;
    logic [WIDTH-1:0] mem_rd;
    fifo_flags_t      flags_q;
    fifo_flags_t      flags_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign wr_fifo = wr_en && data_in_vld && !flags_q.full;
    assign rd_fifo = rd_en && !flags_q.empty;

    always_comb begin
        count_nxt = count;
        case ({wr_fifo, rd_fifo})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Flags are registered from the next count, so they always equal the
    // decode of the registered count without a decode after the flop.
    always_comb begin
        flags_d              = RST_FLAGS;
        flags_d.full         = (count_nxt == CW'(DEPTH));
        flags_d.empty        = (count_nxt == '0);
        flags_d.almost_full  = (count_nxt >= CW'(AFULL_TH));
        flags_d.almost_empty = (count_nxt <= CW'(AEMPTY_TH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            flags_q   <= RST_FLAGS;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_fifo) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_fifo) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count     <= count_nxt;
            flags_q   <= flags_d;
            overflow  <= wr_en && data_in_vld && flags_q.full;
            underflow <= rd_en && flags_q.empty;
        end
    end

    assign full         = flags_q.full;
    assign empty        = flags_q.empty;
    assign almost_full  = flags_q.almost_full;
    assign almost_empty = flags_q.almost_empty;

    param_sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_fifo),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (mem_rd)
    );

`ifdef PARAM_SYNC_FIFO_FWFT_EN
    // Head entry is always presented; rd_en only acknowledges it.
    assign rd_data      = mem_rd;
    assign data_out_vld = !flags_q.empty;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data      <= '0;
            data_out_vld <= 1'b0;
        end else begin
            data_out_vld <= rd_fifo;
            if (rd_fifo) begin
                rd_data <= mem_rd;
            end
        end
    end
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench for param_sync_fifo (WIDTH=8, DEPTH=4): table of
// per-cycle vectors plus a queue model / scoreboard for read data.
module tb_param_sync_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic       data_in_vld = 1'b0;
    logic [7:0] data_in = '0;
    logic       rd_en = 1'b0;
    logic       full, empty, almost_full, almost_empty;
    logic [2:0] count;
    logic [7:0] rd_data;
    logic       data_out_vld, overflow, underflow;

    param_sync_fifo #(
        .WIDTH     (8),
        .DEPTH     (4),
        .AFULL_TH  (3),
        .AEMPTY_TH (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .data_in_vld  (data_in_vld),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .rd_data      (rd_data),
        .data_out_vld (data_out_vld),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        wr;
        logic        vld;
        logic [7:0]  din;
        logic        rd;
        int unsigned cnt;
        logic        ovf;
        logic        udf;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] mq[$];   // model FIFO contents
    logic [7:0] sb[$];   // expected registered read data
    int         n_vec  = 0;
    int         n_cmp  = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic r, input logic w, input logic v,
                                input logic [7:0] d, input logic rd,
                                input int unsigned c, input logic o, input logic u);
        vec_t t;
        t.rst = r; t.wr = w; t.vld = v; t.din = d; t.rd = rd;
        t.cnt = c; t.ovf = o; t.udf = u;
        vecs.push_back(t);
    endfunction

    task automatic step(input vec_t v);
        logic rd_ok, wr_ok;
        @(negedge clk);
        rst = v.rst; wr_en = v.wr; data_in_vld = v.vld; data_in = v.din; rd_en = v.rd;
        @(posedge clk);
        if (v.rst) begin
            mq.delete();
            sb.delete();
        end else begin
            rd_ok = v.rd && (mq.size() > 0);
            wr_ok = v.wr && v.vld && (mq.size() < 4);
            if (rd_ok) sb.push_back(mq.pop_front());
            if (wr_ok) mq.push_back(v.din);
        end
        #1;
        n_vec++;
        chk("count",        32'(count),        32'(v.cnt));
        chk("full",         32'(full),         32'(v.cnt == 4));
        chk("empty",        32'(empty),        32'(v.cnt == 0));
        chk("almost_full",  32'(almost_full),  32'(v.cnt >= 3));
        chk("almost_empty", 32'(almost_empty), 32'(v.cnt <= 1));
        chk("overflow",     32'(overflow),     32'(v.ovf));
        chk("underflow",    32'(underflow),    32'(v.udf));
`ifdef PARAM_SYNC_FIFO_FWFT_EN
        chk("data_out_vld", 32'(data_out_vld), 32'(mq.size() > 0));
        if (mq.size() > 0) chk("rd_data", 32'(rd_data), 32'(mq[0]));
`else
        if (v.rst) chk("rd_data_rst", 32'(rd_data), 32'h0);
        if (sb.size() > 0) begin
            chk("data_out_vld", 32'(data_out_vld), 32'h1);
            chk("rd_data", 32'(rd_data), 32'(sb.pop_front()));
        end else begin
            chk("data_out_vld", 32'(data_out_vld), 32'h0);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t h;
        logic [7:0] hold;
        //   rst wr vld din    rd  cnt ovf udf
        add(1, 0, 0, 8'h00, 0, 0, 0, 0);
        // fill and overflow
        add(0, 1, 1, 8'h11, 0, 1, 0, 0);
        add(0, 1, 1, 8'h22, 0, 2, 0, 0);
        add(0, 1, 1, 8'h33, 0, 3, 0, 0);
        add(0, 1, 1, 8'h44, 0, 4, 0, 0);
        add(0, 1, 1, 8'h55, 0, 4, 1, 0);
        add(0, 0, 0, 8'h00, 0, 4, 0, 0);
        // drain and underflow
        add(0, 0, 0, 8'h00, 1, 3, 0, 0);
        add(0, 0, 0, 8'h00, 1, 2, 0, 0);
        add(0, 0, 0, 8'h00, 1, 1, 0, 0);
        add(0, 0, 0, 8'h00, 1, 0, 0, 0);
        add(0, 0, 0, 8'h00, 1, 0, 0, 1);
        add(0, 0, 0, 8'h00, 0, 0, 0, 0);
        // wrap: ten write/read pairs
        for (int unsigned i = 0; i < 10; i++) begin
            add(0, 1, 1, 8'(i), 0, 1, 0, 0);
            add(0, 0, 0, 8'h00, 1, 0, 0, 0);
        end
        // write without data_in_vld is ignored
        add(0, 1, 0, 8'hEE, 0, 0, 0, 0);
        // simultaneous at empty: write taken, read rejected
        add(0, 1, 1, 8'hBB, 1, 1, 0, 1);
        add(0, 0, 0, 8'h00, 1, 0, 0, 0);
        // simultaneous at full and mid-level
        add(0, 1, 1, 8'hA0, 0, 1, 0, 0);
        add(0, 1, 1, 8'hA1, 0, 2, 0, 0);
        add(0, 1, 1, 8'hA2, 0, 3, 0, 0);
        add(0, 1, 1, 8'hA3, 0, 4, 0, 0);
        add(0, 1, 1, 8'hAA, 1, 3, 1, 0);
        add(0, 0, 0, 8'h00, 1, 2, 0, 0);
        add(0, 1, 1, 8'hAC, 1, 2, 0, 0);
        add(0, 0, 0, 8'h00, 1, 1, 0, 0);
        add(0, 0, 0, 8'h00, 1, 0, 0, 0);
        // reset mid-operation with concurrent requests
        add(0, 1, 1, 8'h01, 0, 1, 0, 0);
        add(0, 1, 1, 8'h02, 0, 2, 0, 0);
        add(0, 1, 1, 8'h03, 0, 3, 0, 0);
        add(1, 1, 1, 8'h04, 1, 0, 0, 0);
        add(0, 0, 0, 8'h00, 1, 0, 0, 1);
        add(0, 1, 1, 8'h5A, 0, 1, 0, 0);
        add(0, 0, 0, 8'h00, 1, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i]);
        end

        // rd_data holds across idle cycles once the valid pulse has passed
        hold = rd_data;
        h = '{rst: 0, wr: 0, vld: 0, din: 8'h00, rd: 0, cnt: 0, ovf: 0, udf: 0};
        step(h);
        step(h);
`ifndef PARAM_SYNC_FIFO_FWFT_EN
        chk("rd_data_hold", 32'(rd_data), 32'h5A);
        chk("rd_data_hold_prev", 32'(hold), 32'h5A);
`endif

`ifdef PARAM_SYNC_FIFO_FWFT_EN
        // head entry falls through without rd_en, then pop empties it
        h = '{rst: 0, wr: 1, vld: 1, din: 8'h77, rd: 0, cnt: 1, ovf: 0, udf: 0};
        step(h);
        chk("fwft_data", 32'(rd_data), 32'h77);
        chk("fwft_vld", 32'(data_out_vld), 32'h1);
        h = '{rst: 0, wr: 0, vld: 0, din: 8'h00, rd: 1, cnt: 0, ovf: 0, udf: 0};
        step(h);
        chk("fwft_vld_after_pop", 32'(data_out_vld), 32'h0);
        chk("fwft_empty", 32'(empty), 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, entry count (>=2, any integer, not restricted to powers of two).
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-1, almost_full threshold in entries (1..DEPTH).
REQ-004 SHALL have parameter AEMPTY_TH, default 1, almost_empty threshold in entries (0..DEPTH-1).
REQ-005 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-006 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports: wr_en  in  1, data_in_vld  in  1, data_in  in  WIDTH  (write request and data).
REQ-008 SHALL have ports: rd_en  in  1  read request / pop.
REQ-009 SHALL have ports: full, empty, almost_full, almost_empty  out  1  status flags.
REQ-010 SHALL have ports: count  out  CW=$clog2(DEPTH+1)  current occupancy.
REQ-011 SHALL have ports: rd_data  out  WIDTH, data_out_vld  out  1  (read data and its qualifier).
REQ-012 SHALL have ports: overflow, underflow  out  1  one-cycle error pulses.

Function
REQ-013 SHALL accept a write (wr_fifo) iff wr_en && data_in_vld && !full.
REQ-014 SHALL accept a read (rd_fifo) iff rd_en && !empty.
REQ-015 SHALL store data_in at wr_ptr on wr_fifo; wr_ptr increments, wrapping DEPTH-1 -> 0.
REQ-016 SHALL advance rd_ptr on rd_fifo, wrapping DEPTH-1 -> 0.
REQ-017 SHALL update count registered: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-018 SHALL derive full = (count==DEPTH), empty = (count==0), almost_full = (count>=AFULL_TH), almost_empty = (count<=AEMPTY_TH), all from registered count.
REQ-019 SHALL, on simultaneous request when full, accept the read and reject the write; when empty, accept the write and reject the read.
REQ-020 SHALL, on simultaneous accepted read and write at 0<count<DEPTH, perform both with count unchanged.
REQ-021 SHALL, in standard mode, register rd_data <= mem[rd_ptr] on rd_fifo and pulse data_out_vld high exactly one cycle later (read latency 1); rd_data holds its value otherwise.
REQ-022 SHALL make write-to-empty-deassert latency 1 cycle (empty low the cycle after wr_fifo).
REQ-023 SHALL pulse overflow one cycle after wr_en && data_in_vld && full; underflow one cycle after rd_en && empty.

Reset
REQ-024 SHALL, on rst high at a clk edge, clear wr_ptr, rd_ptr, count, data_out_vld, overflow and underflow to 0; empty=1, full=0, almost_empty=1, almost_full=0.
REQ-025 SHALL clear rd_data to 0 on reset; memory contents are not reset.
REQ-026 SHALL give reset priority over any concurrent write or read; a mid-operation reset discards all entries.

Configuration
REQ-027 SHALL, with macro PARAM_SYNC_FIFO_FWFT_EN defined, operate first-word-fall-through: rd_data = mem[rd_ptr] continuously, data_out_vld = !empty, rd_en acts as pop acknowledge, read latency 0.
REQ-028 SHALL, without PARAM_SYNC_FIFO_FWFT_EN, operate in standard registered-read mode per REQ-021.
REQ-029 SHALL keep flags, count, pointers and error pulses identical in both modes.

Structure
REQ-030 SHALL place in shared package param_sync_fifo_pkg: pointer/count width helper function and the reset-value constants for flags.
REQ-031 SHALL implement storage in sub-module param_sync_fifo_mem (1 write port, 1 async read port, WIDTH x DEPTH), with pointer/flag control in the top.

Verification (WIDTH=8, DEPTH=4, AFULL_TH=3, AEMPTY_TH=1, standard mode unless stated)
REQ-032 SHALL cover fill: write 0x11,0x22,0x33,0x44 -> count 1..4, almost_full at count 3, full at 4; fifth write 0x55 -> overflow pulse, count stays 4.
REQ-033 SHALL cover drain: read 4x after fill -> rd_data 0x11,0x22,0x33,0x44 each with 1-cycle data_out_vld, empty after last; extra read -> underflow pulse.
REQ-034 SHALL cover wrap: 10 interleaved write/read pairs of 0x00..0x09 -> outputs in order, count never exceeds 1, pointers wrap twice.
REQ-035 SHALL cover simultaneous: at full, rd_en+wr_en 0xAA -> read accepted, write rejected, count 3; at count 2, both -> count 2.
REQ-036 SHALL cover reset mid-operation: count 3, rst one cycle -> count 0, empty 1, next read returns nothing, next write 0x5A reads back 0x5A.
REQ-037 SHALL cover FWFT build: write 0x77 to empty -> next cycle rd_data 0x77, data_out_vld 1 without rd_en; rd_en -> empty, data_out_vld 0.
